// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the shift request controller and its arbiter.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_CAPTURE = 2'd3
  } shift_ctrl_state_e;

  localparam logic SHIFT_LEFT  = 1'b1;
  localparam logic SHIFT_RIGHT = 1'b0;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_AMT_W    = 5;
  localparam int DEF_STEP_MAX = 4;

endpackage

// File: rtl/shift_req_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner on each accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       winner
);

  logic ptr;

  always_comb begin
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ptr;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= 1'b0;
    else if (accept) ptr <= ~winner;
  end

endmodule

// File: rtl/shift_req_ctrl.sv
// Arbitrates two shift clients and sequences the shared shifter through load,
// bounded shift steps and result capture.
//   state   | meaning
//   IDLE    | waiting for a request; arbitrates and latches the winning job
//   LOAD    | gnt + sh_start pulse, shifter loads the operand
//   SHIFT   | one sh_enb step per cycle until the remaining amount is zero
//   CAPTURE | shifter output settled; result/done registered on exit
module shift_req_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AMT_W    = DEF_AMT_W,
  parameter int STEP_MAX = DEF_STEP_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [AMT_W-1:0] req_amt0,
  input  logic [AMT_W-1:0] req_amt1,
  input  logic [1:0]       req_dir,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             sh_start,
  output logic             sh_enb,
  output logic [WIDTH-1:0] sh_data,
  output logic [WIDTH-1:0] sh_shift_value,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_result
);

  localparam int REM_W = $clog2(WIDTH + 1);

  shift_ctrl_state_e state;
  logic [REM_W-1:0]  rem;
  logic [REM_W-1:0]  rem_step;
  logic [REM_W-1:0]  amt_clamped;
  logic [AMT_W-1:0]  win_amt;
  logic              winner;
  logic              job_id;
  logic              accept;

  assign accept = (state == ST_IDLE) && (req != 2'b00);
  assign busy   = (state != ST_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .winner (winner)
  );

  always_comb begin
    win_amt     = winner ? req_amt1 : req_amt0;
    amt_clamped = (32'(win_amt) > WIDTH) ? REM_W'(WIDTH) : REM_W'(win_amt);
    rem_step    = (32'(rem) > STEP_MAX) ? REM_W'(STEP_MAX) : rem;
  end

  // Strobes are registered one state ahead so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      rem            <= '0;
      job_id         <= 1'b0;
      gnt            <= '0;
      done           <= 1'b0;
      done_id        <= 1'b0;
      result         <= '0;
      sh_start       <= 1'b0;
      sh_enb         <= 1'b0;
      sh_data        <= '0;
      sh_shift_value <= '0;
      sh_dir         <= 1'b0;
    end else begin
      gnt            <= '0;
      sh_start       <= 1'b0;
      sh_enb         <= 1'b0;
      sh_shift_value <= '0;
      done           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_LOAD;
            job_id   <= winner;
            gnt      <= winner ? 2'b10 : 2'b01;
            sh_start <= 1'b1;
            sh_data  <= winner ? req_data1 : req_data0;
            sh_dir   <= req_dir[winner];
            rem      <= amt_clamped;
          end
        end
        ST_LOAD, ST_SHIFT: begin
          if (rem != '0) begin
            state          <= ST_SHIFT;
            sh_enb         <= 1'b1;
            sh_shift_value <= WIDTH'(rem_step);
            rem            <= rem - rem_step;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          result  <= sh_result;
          done    <= 1'b1;
          done_id <= job_id;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
